// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: handshaked pipeline stage with 2-entry skid buffer, stall, flush, bubble and flush-discard counter
//   clk/rst                        clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_ctrl      upstream handshake and entry
//   out_valid/out_ready/out_data/out_ctrl  downstream handshake and head entry
//   stall/flush/bubble             freeze, discard all, enqueue a zero NOP
//   occupancy/flush_cnt            held entries, saturating discarded-entry count
module pipe_stage_skid #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t            r_state;
  logic [DATA_W-1:0] r_h_data, r_s_data;
  logic [CTRL_W-1:0] r_h_ctrl, r_s_ctrl;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_live, w_enq, w_pop;
  logic [DATA_W-1:0] w_new_data;
  logic [CTRL_W-1:0] w_new_ctrl;
  logic [CNT_W:0]    w_sum;
  assign w_live     = !rst & !flush & !stall;
  assign in_ready   = w_live & !bubble & (r_state != FULL);
  assign out_valid  = w_live & (r_state != EMPTY);
  assign w_pop      = out_valid & out_ready;
  // a bubble takes the enqueue slot in place of upstream, which sees in_ready=0
  assign w_enq      = w_live & (r_state != FULL) & (bubble | in_valid);
  assign w_new_data = bubble ? '0 : in_data;
  assign w_new_ctrl = bubble ? '0 : in_ctrl;
  // one extra bit catches overflow so the count saturates instead of wrapping
  assign w_sum      = {1'b0, r_cnt} + (CNT_W+1)'(r_state);
  assign out_data   = r_h_data;
  assign out_ctrl   = r_h_ctrl;
  assign occupancy  = r_state;
  assign flush_cnt  = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_h_data <= '0;
      r_h_ctrl <= '0;
      r_s_data <= '0;
      r_s_ctrl <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_state  <= EMPTY;
      r_h_data <= '0;
      r_h_ctrl <= '0;
      r_s_data <= '0;
      r_s_ctrl <= '0;
      r_cnt    <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end else begin
      case (r_state)
        EMPTY: if (w_enq) begin
          r_state  <= ONE;
          r_h_data <= w_new_data;
          r_h_ctrl <= w_new_ctrl;
        end
        ONE: if (w_enq & w_pop) begin
          r_h_data <= w_new_data;
          r_h_ctrl <= w_new_ctrl;
        end else if (w_enq) begin
          r_state  <= FULL;
          r_s_data <= w_new_data;
          r_s_ctrl <= w_new_ctrl;
        end else if (w_pop) begin
          r_state  <= EMPTY;
          r_h_data <= '0;
          r_h_ctrl <= '0;
        end
        FULL: if (w_pop) begin
          r_state  <= ONE;
          r_h_data <= r_s_data;
          r_h_ctrl <= r_s_ctrl;
          r_s_data <= '0;
          r_s_ctrl <= '0;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: random and directed stimulus against a queue-based model of the stage
module tb_pipe_stage_skid;
  localparam int DATA_W = 16, CTRL_W = 24, CNT_W = 2;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic stall = 0, flush = 0, bubble = 0;
  logic [DATA_W-1:0] in_data = '0, out_data;
  logic [CTRL_W-1:0] in_ctrl = '0, out_ctrl;
  logic [1:0] occupancy;
  logic [CNT_W-1:0] flush_cnt;
  int total = 0, bad = 0, m_cnt = 0;
  bit done = 0;
  logic [DATA_W+CTRL_W-1:0] q[$];
  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall(stall), .flush(flush), .bubble(bubble),
    .occupancy(occupancy), .flush_cnt(flush_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic fill2(input logic [15:0] a, input logic [15:0] b);
    out_ready = 0; in_valid = 1;
    in_data = a; in_ctrl = 24'h0A0000 | 24'(a); cyc();
    in_data = b; in_ctrl = 24'h0B0000 | 24'(b); cyc();
    in_valid = 0;
  endtask
  // model: entries are a FIFO of depth 2; outputs follow from its size and the control inputs
  initial begin
    @(negedge clk);
    while (!done) begin
      logic live, m_ready, m_valid;
      live    = !rst && !flush && !stall;
      m_ready = live && !bubble && q.size() < 2;
      m_valid = live && q.size() > 0;
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_cnt));
      chk("head", 64'({out_ctrl, out_data}), q.size() > 0 ? 64'(q[0]) : 64'd0);
      if (rst) begin
        q.delete(); m_cnt = 0;
      end else if (flush) begin
        m_cnt = m_cnt + q.size() > 3 ? 3 : m_cnt + q.size();
        q.delete();
      end else if (live) begin
        logic enq_b, enq_i;
        enq_b = bubble && q.size() < 2;
        enq_i = in_valid && m_ready;
        if (m_valid && out_ready) void'(q.pop_front());
        if (enq_b) q.push_back('0);
        else if (enq_i) q.push_back({in_ctrl, in_data});
      end
      @(negedge clk);
    end
  end
  initial begin
    cyc(); rst = 0;
    out_ready = 1; in_valid = 1;
    for (int i = 1; i <= 5; i++) begin
      in_data = 16'(i); in_ctrl = 24'($urandom); cyc();
    end
    in_valid = 0; cyc(); cyc();
    fill2(16'h00AA, 16'h00BB); cyc();
    out_ready = 1; cyc(); cyc(); cyc();
    fill2(16'h0011, 16'h0022);
    stall = 1; out_ready = 1; in_valid = 1; in_data = 16'h0033;
    cyc(); cyc(); cyc();
    stall = 0; in_valid = 0; cyc(); cyc(); cyc();
    in_valid = 1; in_data = 16'h1234; in_ctrl = 24'h00ABCD; bubble = 1; cyc();
    bubble = 0; cyc(); in_valid = 0; cyc(); cyc(); cyc();
    fill2(16'h0101, 16'h0202); flush = 1; cyc(); flush = 0;
    fill2(16'h0303, 16'h0404); flush = 1; cyc(); flush = 0; cyc();
    flush = 1; cyc(); flush = 0;
    out_ready = 0; in_valid = 1; in_data = 16'h0505; cyc();
    flush = 1; bubble = 1; cyc(); flush = 0; bubble = 0; in_valid = 0; cyc();
    fill2(16'h0606, 16'h0707); rst = 1; cyc(); rst = 0; cyc();
    fill2(16'h0808, 16'h0909); bubble = 1; out_ready = 0; cyc(); cyc();
    out_ready = 1; cyc(); bubble = 0; cyc(); cyc(); cyc();
    for (int i = 0; i < 2000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = 16'($urandom);
      in_ctrl   = 24'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      stall     = $urandom_range(0, 9) == 0;
      bubble    = $urandom_range(0, 7) == 0;
      flush     = $urandom_range(0, 19) == 0;
      rst       = $urandom_range(0, 199) == 0;
      cyc();
    end
    {in_valid, out_ready, stall, bubble, flush, rst} = 6'b010000;
    cyc(); cyc(); cyc();
    done = 1;
    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
